// File: rtl/oam_dma.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from page {DMA,00}
// (echo pages E0..FF fold down by 0x20) into OAM, one byte every
// CYCLES_PER_BYTE clocks. While the copy runs, the CPU only gets the bus
// for high RAM (FF80..FFFE).
module oam_dma #(
  parameter int CYCLES_PER_BYTE = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_di,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [7:0]  cpu_do,
  output logic        cpu_grant,
  output logic        dma_active,
  output logic [15:0] src_addr,
  output logic        src_rd,
  input  logic [7:0]  src_di,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_do,
  output logic        oam_wr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } state_t;

  localparam logic [15:0] REG_ADDR  = 16'hFF46;
  localparam logic [15:0] HRAM_LO   = 16'hFF80;
  localparam logic [15:0] HRAM_HI   = 16'hFFFE;
  localparam logic [7:0]  IDX_LAST  = 8'd159;
  localparam logic [3:0]  SLOT_LAST = 4'(CYCLES_PER_BYTE - 1);

  state_t      state, next_state;
  logic [7:0]  idx, next_idx;
  logic [3:0]  slot, next_slot;
  logic [7:0]  dma_reg;
  logic [7:0]  src_page;
  logic        reg_write;
  logic        reg_read;
  logic        in_hram;

  assign reg_write = cpu_wr && (cpu_addr == REG_ADDR);
  assign reg_read  = cpu_rd && !cpu_wr && (cpu_addr == REG_ADDR);
  assign in_hram   = (cpu_addr >= HRAM_LO) && (cpu_addr <= HRAM_HI);

  // State and byte/slot counters; reset drops any transfer in flight at once
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= 8'd0;
      slot  <= 4'd0;
    end else begin
      state <= next_state;
      idx   <= next_idx;
      slot  <= next_slot;
    end
  end

  // DMA page register; CPU writes always land, even mid-transfer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dma_reg <= 8'hFF;
    end else if (reg_write) begin
      dma_reg <= cpu_di;
    end
  end

  // Registered readback of the page register, held between reads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_do <= 8'h00;
    end else if (reg_read) begin
      cpu_do <= dma_reg;
    end
  end

  // Next-state logic: a register write restarts from START in any state
  always_comb begin
    next_state = state;
    next_idx   = idx;
    next_slot  = slot;
    case (state)
      IDLE: begin
        next_idx  = 8'd0;
        next_slot = 4'd0;
      end
      START: begin
        next_state = XFER;
        next_idx   = 8'd0;
        next_slot  = 4'd0;
      end
      XFER: begin
        if (slot == SLOT_LAST) begin
          next_slot = 4'd0;
          if (idx == IDX_LAST) begin
            next_state = IDLE;
            next_idx   = 8'd0;
          end else begin
            next_idx = idx + 8'd1;
          end
        end else begin
          next_slot = slot + 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_idx   = 8'd0;
        next_slot  = 4'd0;
      end
    endcase
    if (reg_write) begin
      next_state = START;
      next_idx   = 8'd0;
      next_slot  = 4'd0;
    end
  end

  // Source address: echo-RAM pages fold onto the work RAM below them
  always_comb begin
    src_page = (dma_reg < 8'hE0) ? dma_reg : (dma_reg - 8'h20);
    src_addr = {src_page, 8'h00} + {8'h00, idx};
  end

  // Strobes decode from registered state; the source answers one clock
  // after src_rd, so slot 1 forwards src_di straight into OAM
  always_comb begin
    dma_active = (state != IDLE);
    src_rd     = (state == XFER) && (slot == 4'd0);
    oam_wr     = (state == XFER) && (slot == 4'd1);
    oam_addr   = idx;
    oam_do     = src_di;
    cpu_grant  = !dma_active || in_hram;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Testbench for oam_dma: a CPB=4 instance covers the main scenarios
// through a scoreboard of expected OAM writes; a CPB=2 instance covers
// the fastest byte rate.
module tb_oam_dma;

  typedef struct packed {
    logic [7:0]  idx;
    logic [15:0] src;
    logic [7:0]  data;
  } exp_t;

  logic        clock;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_di;
  logic        cpu_wr;
  logic        cpu_wr2;
  logic        cpu_rd;

  logic [7:0]  cpu_do,  cpu_do2;
  logic        cpu_grant, cpu_grant2;
  logic        dma_active, dma_active2;
  logic [15:0] src_addr, src_addr2;
  logic        src_rd, src_rd2;
  logic [7:0]  src_di, src_di2;
  logic [7:0]  oam_addr, oam_addr2;
  logic [7:0]  oam_do, oam_do2;
  logic        oam_wr, oam_wr2;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;

  oam_dma #(.CYCLES_PER_BYTE(4)) dut (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_do(cpu_do), .cpu_grant(cpu_grant), .dma_active(dma_active),
    .src_addr(src_addr), .src_rd(src_rd), .src_di(src_di),
    .oam_addr(oam_addr), .oam_do(oam_do), .oam_wr(oam_wr)
  );

  oam_dma #(.CYCLES_PER_BYTE(2)) dut2 (
    .clock(clock), .reset(reset),
    .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_wr(cpu_wr2), .cpu_rd(cpu_rd),
    .cpu_do(cpu_do2), .cpu_grant(cpu_grant2), .dma_active(dma_active2),
    .src_addr(src_addr2), .src_rd(src_rd2), .src_di(src_di2),
    .oam_addr(oam_addr2), .oam_do(oam_do2), .oam_wr(oam_wr2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: byte content is a scramble of its address
  function automatic logic [7:0] mem_data(input logic [15:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h3C;
  endfunction

  function automatic logic [15:0] exp_base(input logic [7:0] v);
    int p;
    p = (v >= 8'hE0) ? (int'(v) - 32) : int'(v);
    return 16'(p * 256);
  endfunction

  // Source memories answer one clock after a read strobe
  always @(posedge clock) src_di  <= src_rd  ? mem_data(src_addr)  : 8'h00;
  always @(posedge clock) src_di2 <= src_rd2 ? mem_data(src_addr2) : 8'h00;

  task automatic cpu_write(input logic [7:0] v, input bit to_cpb2);
    logic [15:0] s;
    @(negedge clock);
    cpu_addr = 16'hFF46;
    cpu_di   = v;
    if (to_cpb2) cpu_wr2 = 1'b1;
    else         cpu_wr  = 1'b1;
    if (!to_cpb2) begin
      sb.delete();
      for (int i = 0; i < 160; i++) begin
        s = exp_base(v) + 16'(i);
        sb.push_back('{idx: 8'(i), src: s, data: mem_data(s)});
      end
    end
    @(posedge clock);
    #1;
    cpu_wr  = 1'b0;
    cpu_wr2 = 1'b0;
  endtask

  task automatic cpu_read(input string name, input logic [7:0] exp);
    @(negedge clock);
    cpu_addr = 16'hFF46;
    cpu_rd   = 1'b1;
    @(posedge clock);
    #1;
    cpu_rd = 1'b0;
    n_cmp++;
    if (cpu_do !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: cpu_do got %h want %h", name, cpu_do, exp);
    end
  endtask

  // Follows a CPB=4 transfer, popping the scoreboard on each OAM write;
  // stop_idx >= 0 returns right after that index has been written
  task automatic watch(input string name, input int budget, input int stop_idx,
                       input int exp_active, input int exp_writes);
    int          active_cnt;
    int          wr_cnt;
    bit          stopped;
    logic [15:0] last_src;
    exp_t        e;
    active_cnt = 0;
    wr_cnt     = 0;
    stopped    = 1'b0;
    last_src   = 16'h0000;
    for (int c = 0; c < budget; c++) begin
      @(negedge clock);
      if (src_rd) last_src = src_addr;
      if (dma_active) active_cnt++;
      if (oam_wr) begin
        wr_cnt++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("[TB] FAIL %s unexpected_write: oam_addr got %h want none", name, oam_addr);
        end else begin
          e = sb.pop_front();
          if (oam_addr !== e.idx || oam_do !== e.data || last_src !== e.src) begin
            n_bad++;
            $display("[TB] FAIL %s write: idx/src/data got %h/%h/%h want %h/%h/%h",
                     name, oam_addr, last_src, oam_do, e.idx, e.src, e.data);
          end
        end
        if (stop_idx >= 0 && int'(oam_addr) == stop_idx) stopped = 1'b1;
      end
      if (stopped || !dma_active) break;
    end
    if (stop_idx >= 0) begin
      n_cmp++;
      if (!stopped) begin
        n_bad++;
        $display("[TB] FAIL %s reach_idx: reached %0d want 1", name, stopped);
      end
    end else begin
      n_cmp++;
      if (active_cnt != exp_active) begin
        n_bad++;
        $display("[TB] FAIL %s active_clocks: got %0d want %0d", name, active_cnt, exp_active);
      end
      n_cmp++;
      if (wr_cnt != exp_writes || sb.size() != 0 || dma_active !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL %s writes: got %0d left %0d active %b want %0d left 0 active 0",
                 name, wr_cnt, sb.size(), dma_active, exp_writes);
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    cpu_addr = 16'h0000;
    cpu_di   = 8'h00;
    cpu_wr   = 1'b0;
    cpu_wr2  = 1'b0;
    cpu_rd   = 1'b0;
    #1;
    n_cmp++;
    if ({dma_active, src_rd, oam_wr, dma_active2, src_rd2, oam_wr2} !== 6'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_strobes: got %b want 000000",
               {dma_active, src_rd, oam_wr, dma_active2, src_rd2, oam_wr2});
    end
    n_cmp++;
    if (cpu_do !== 8'h00 || cpu_grant !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL reset_cpu: cpu_do/grant got %h/%b want 00/1", cpu_do, cpu_grant);
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    cpu_read("reset_readback", 8'hFF);
  endtask

  task automatic test_basic();
    n_cmp++;
    if (dma_active !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL basic_idle: dma_active got %b want 0", dma_active);
    end
    cpu_write(8'hC1, 1'b0);
    n_cmp++;
    if (dma_active !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL basic_rise: dma_active got %b want 1", dma_active);
    end
    watch("basic", 2000, -1, 641, 160);
  endtask

  task automatic test_echo_and_read();
    cpu_write(8'hE3, 1'b0);
    watch("echo", 2000, -1, 641, 160);
    cpu_read("echo_readback", 8'hE3);
    @(negedge clock);
    cpu_addr = 16'h1234;
    @(negedge clock);
    n_cmp++;
    if (cpu_do !== 8'hE3) begin
      n_bad++;
      $display("[TB] FAIL echo_hold: cpu_do got %h want e3", cpu_do);
    end
  endtask

  task automatic test_grant();
    logic [15:0] addrs [7];
    logic        want  [7];
    bit          done;
    addrs = '{16'hFF90, 16'h8000, 16'hFF7F, 16'hFF80, 16'hFFFE, 16'hFFFF, 16'hFF46};
    want  = '{1'b1,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b0};
    cpu_write(8'h40, 1'b0);
    sb.delete();
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      cpu_addr = addrs[i];
      #1;
      n_cmp++;
      if (cpu_grant !== want[i]) begin
        n_bad++;
        $display("[TB] FAIL grant_busy %h: got %b want %b", addrs[i], cpu_grant, want[i]);
      end
    end
    done = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clock);
      if (!dma_active) done = 1'b1;
    end
    cpu_addr = 16'h8000;
    #1;
    n_cmp++;
    if (!done || cpu_grant !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL grant_after: done/grant got %b/%b want 1/1", done, cpu_grant);
    end
  endtask

  task automatic test_back_to_back();
    cpu_write(8'hC0, 1'b0);
    watch("restart_old", 2000, 50, 0, 0);
    cpu_write(8'hD0, 1'b0);
    watch("restart_new", 2000, -1, 641, 160);
  endtask

  task automatic test_reset_abort();
    int strobes;
    cpu_write(8'hC1, 1'b0);
    watch("abort", 2000, 80, 0, 0);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({dma_active, oam_wr, src_rd} !== 3'b000) begin
      n_bad++;
      $display("[TB] FAIL abort_async: active/wr/rd got %b want 000", {dma_active, oam_wr, src_rd});
    end
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    strobes = 0;
    repeat (12) begin
      @(negedge clock);
      if (dma_active || oam_wr || src_rd) strobes++;
    end
    n_cmp++;
    if (strobes != 0) begin
      n_bad++;
      $display("[TB] FAIL abort_quiet: strobe cycles got %0d want 0", strobes);
    end
    cpu_read("abort_readback", 8'hFF);
  endtask

  task automatic test_fast_rate();
    int active_cnt;
    int bad_alt;
    int wr_cnt;
    int bad_data;
    logic [15:0] s;
    active_cnt = 0;
    bad_alt    = 0;
    wr_cnt     = 0;
    bad_data   = 0;
    cpu_write(8'h12, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clock);
      if (!dma_active2) break;
      active_cnt++;
      if (active_cnt > 1 && src_rd2 == oam_wr2) bad_alt++;
      if (oam_wr2) begin
        s = 16'h1200 + 16'(wr_cnt);
        if (oam_addr2 !== 8'(wr_cnt) || oam_do2 !== mem_data(s)) bad_data++;
        wr_cnt++;
      end
    end
    n_cmp++;
    if (active_cnt != 321) begin
      n_bad++;
      $display("[TB] FAIL cpb2_active: got %0d want 321", active_cnt);
    end
    n_cmp++;
    if (bad_alt != 0) begin
      n_bad++;
      $display("[TB] FAIL cpb2_alternate: bad cycles got %0d want 0", bad_alt);
    end
    n_cmp++;
    if (wr_cnt != 160 || bad_data != 0) begin
      n_bad++;
      $display("[TB] FAIL cpb2_writes: count/bad got %0d/%0d want 160/0", wr_cnt, bad_data);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_echo_and_read();
    test_grant();
    test_back_to_back();
    test_reset_abort();
    test_fast_rate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
